// File: rtl/comparador_checker.sv
// comparador_checker
// ------------------
// Response monitor for an 8-bit magnitude comparator (Comparador_8bits).
// Each applied A/B pair is compared internally, and the result is checked
// against the G/L/E that the comparator returns LAT cycles later. The
// checker keeps a sticky pass/fail state, saturating vector and error
// counters, and a capture of the first failing vector.
//
// Handshake: in_valid qualifies a/b for exactly the cycle it is high. There
// is no ready. The checker accepts one vector on every cycle, back to back,
// and a vector is never stalled.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear of all state, pipeline included
//   in_valid   a/b hold a vector applied to the comparator this cycle
//   a, b       operands as applied to the comparator
//   g, l, e    comparator outputs, valid LAT cycles after the vector
//   state      00 IDLE, 01 PASS, 10 FAIL (also serves as FSM debug view)
//   err        sticky error flag, high while state is FAIL
//   vec_count  vectors checked (saturating)
//   err_count  mismatching vectors (saturating)
//   ff_a/ff_b  operands of the first failing vector
//   ff_obs     {g,l,e} observed on the first failure
//   ff_exp     {G,L,E} expected on the first failure
module comparador_checker #(
  parameter int WIDTH = 8,
  parameter int LAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             g,
  input  logic             l,
  input  logic             e,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [2:0]       ff_obs,
  output logic [2:0]       ff_exp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Expected comparator response for the vector on the inputs now.
  logic [2:0] exp_now;
  assign exp_now = {a > b, a < b, a == b};

  // Signals of the vector whose response is due at this edge.
  logic             chk_valid;
  logic [WIDTH-1:0] chk_a;
  logic [WIDTH-1:0] chk_b;
  logic [2:0]       chk_exp;

  generate
    if (LAT == 0) begin : g_direct
      assign chk_valid = in_valid;
      assign chk_a     = a;
      assign chk_b     = b;
      assign chk_exp   = exp_now;
    end else begin : g_pipe
      // Alignment delay line. Stage 0 is written at the edge that accepts
      // the vector, so stage LAT-1 lines up with the response LAT edges on.
      logic [LAT-1:0]   pv;
      logic [WIDTH-1:0] pa [LAT];
      logic [WIDTH-1:0] pb [LAT];
      logic [2:0]       pe [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
          for (int i = 0; i < LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
            pe[i] <= '0;
          end
        end else if (clear) begin
          pv <= '0;
          for (int i = 0; i < LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
            pe[i] <= '0;
          end
        end else begin
          pv[0] <= in_valid;
          pa[0] <= a;
          pb[0] <= b;
          pe[0] <= exp_now;
          for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      assign chk_valid = pv[LAT-1];
      assign chk_a     = pa[LAT-1];
      assign chk_b     = pb[LAT-1];
      assign chk_exp   = pe[LAT-1];
    end
  endgenerate

  // Any observed pattern other than the one-hot expected value is a miss,
  // including 000, 011 and 111.
  logic [2:0] obs;
  logic       mismatch;
  assign obs      = {g, l, e};
  assign mismatch = (obs != chk_exp);

  state_t           state_q;
  logic             err_q;
  logic [CNT_W-1:0] vec_q;
  logic [CNT_W-1:0] errc_q;
  logic [WIDTH-1:0] ff_a_q;
  logic [WIDTH-1:0] ff_b_q;
  logic [2:0]       ff_obs_q;
  logic [2:0]       ff_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      vec_q    <= '0;
      errc_q   <= '0;
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_obs_q <= '0;
      ff_exp_q <= '0;
    end else if (clear) begin
      // clear beats a check event landing on the same edge.
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      vec_q    <= '0;
      errc_q   <= '0;
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_obs_q <= '0;
      ff_exp_q <= '0;
    end else if (chk_valid) begin
      if (vec_q != CNT_MAX) vec_q <= vec_q + CNT_ONE;
      if (mismatch) begin
        if (errc_q != CNT_MAX) errc_q <= errc_q + CNT_ONE;
        // Capture only on the entry into FAIL; FAIL is sticky.
        if (state_q != ST_FAIL) begin
          state_q  <= ST_FAIL;
          err_q    <= 1'b1;
          ff_a_q   <= chk_a;
          ff_b_q   <= chk_b;
          ff_obs_q <= obs;
          ff_exp_q <= chk_exp;
        end
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_PASS;
      end
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign vec_count = vec_q;
  assign err_count = errc_q;
  assign ff_a      = ff_a_q;
  assign ff_b      = ff_b_q;
  assign ff_obs    = ff_obs_q;
  assign ff_exp    = ff_exp_q;

endmodule

// File: tb/tb_comparador_checker.sv
// Testbench for comparador_checker. Three instances are built:
//   u_lat0 : LAT=0, CNT_W=16  (directed vector table)
//   u_lat2 : LAT=2, CNT_W=16  (back-to-back stream, misaligned stream, reset)
//   u_cnt4 : LAT=0, CNT_W=4   (counter saturation, clear vs in_valid)
module tb_comparador_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT signals ----------------
  logic        s0_clear, s0_in_valid, s0_g, s0_l, s0_e;
  logic [7:0]  s0_a, s0_b;
  logic [1:0]  s0_state;
  logic        s0_err;
  logic [15:0] s0_vec, s0_errc;
  logic [7:0]  s0_ff_a, s0_ff_b;
  logic [2:0]  s0_ff_obs, s0_ff_exp;

  logic        s2_clear, s2_in_valid, s2_g, s2_l, s2_e;
  logic [7:0]  s2_a, s2_b;
  logic [1:0]  s2_state;
  logic        s2_err;
  logic [15:0] s2_vec, s2_errc;
  logic [7:0]  s2_ff_a, s2_ff_b;
  logic [2:0]  s2_ff_obs, s2_ff_exp;

  logic        s4_clear, s4_in_valid, s4_g, s4_l, s4_e;
  logic [7:0]  s4_a, s4_b;
  logic [1:0]  s4_state;
  logic        s4_err;
  logic [3:0]  s4_vec, s4_errc;
  logic [7:0]  s4_ff_a, s4_ff_b;
  logic [2:0]  s4_ff_obs, s4_ff_exp;

  comparador_checker #(.WIDTH(8), .LAT(0), .CNT_W(16)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .clear(s0_clear), .in_valid(s0_in_valid),
    .a(s0_a), .b(s0_b), .g(s0_g), .l(s0_l), .e(s0_e),
    .state(s0_state), .err(s0_err), .vec_count(s0_vec), .err_count(s0_errc),
    .ff_a(s0_ff_a), .ff_b(s0_ff_b), .ff_obs(s0_ff_obs), .ff_exp(s0_ff_exp)
  );

  comparador_checker #(.WIDTH(8), .LAT(2), .CNT_W(16)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .clear(s2_clear), .in_valid(s2_in_valid),
    .a(s2_a), .b(s2_b), .g(s2_g), .l(s2_l), .e(s2_e),
    .state(s2_state), .err(s2_err), .vec_count(s2_vec), .err_count(s2_errc),
    .ff_a(s2_ff_a), .ff_b(s2_ff_b), .ff_obs(s2_ff_obs), .ff_exp(s2_ff_exp)
  );

  comparador_checker #(.WIDTH(8), .LAT(0), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst_n(rst_n), .clear(s4_clear), .in_valid(s4_in_valid),
    .a(s4_a), .b(s4_b), .g(s4_g), .l(s4_l), .e(s4_e),
    .state(s4_state), .err(s4_err), .vec_count(s4_vec), .err_count(s4_errc),
    .ff_a(s4_ff_a), .ff_b(s4_ff_b), .ff_obs(s4_ff_obs), .ff_exp(s4_ff_exp)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference compare used to build correctly aligned responses.
  function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y);
    return {x > y, x < y, x == y};
  endfunction

  // Stream pattern: cycles through 80/80, FF/80, 80/FF, FF/FF.
  function automatic logic [7:0] pat_a(input int c);
    return (c % 2 == 1) ? 8'hFF : 8'h80;
  endfunction
  function automatic logic [7:0] pat_b(input int c);
    return ((c % 4) < 2) ? 8'h80 : 8'hFF;
  endfunction

  // ---------------- vector table for u_lat0 ----------------
  typedef struct packed {
    logic        clr;
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  gle;
    logic [1:0]  st;
    logic [15:0] vec;
    logic [15:0] errc;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic clr, input logic v, input logic [7:0] a,
                              input logic [7:0] b, input logic [2:0] gle,
                              input logic [1:0] st, input logic [15:0] vec,
                              input logic [15:0] errc);
    vec_t r;
    r.clr = clr; r.v = v; r.a = a; r.b = b; r.gle = gle;
    r.st = st; r.vec = vec; r.errc = errc;
    return r;
  endfunction

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      s0_clear    = tbl[i].clr;
      s0_in_valid = tbl[i].v;
      s0_a        = tbl[i].a;
      s0_b        = tbl[i].b;
      {s0_g, s0_l, s0_e} = tbl[i].gle;
      tick();
      chk($sformatf("lat0_row%0d_state", i), s0_state, tbl[i].st);
      chk($sformatf("lat0_row%0d_vec", i), s0_vec, tbl[i].vec);
      chk($sformatf("lat0_row%0d_errc", i), s0_errc, tbl[i].errc);
      chk($sformatf("lat0_row%0d_err", i), s0_err, tbl[i].st == 2'b10);
    end
    s0_clear    = 1'b0;
    s0_in_valid = 1'b0;
  endtask

  task automatic chk_ff0(input string tag, input logic [7:0] fa, input logic [7:0] fb,
                         input logic [2:0] fo, input logic [2:0] fe);
    chk({tag, "_ff_a"}, s0_ff_a, fa);
    chk({tag, "_ff_b"}, s0_ff_b, fb);
    chk({tag, "_ff_obs"}, s0_ff_obs, fo);
    chk({tag, "_ff_exp"}, s0_ff_exp, fe);
  endtask

  // Drives 18 cycles on u_lat2: 16 vectors back to back, responses d cycles late.
  task automatic run_lat2(input int d);
    for (int c = 0; c < 18; c++) begin
      s2_in_valid = (c < 16);
      s2_a = pat_a(c);
      s2_b = pat_b(c);
      if (c >= d && (c - d) < 16) {s2_g, s2_l, s2_e} = ref_cmp(pat_a(c - d), pat_b(c - d));
      else {s2_g, s2_l, s2_e} = 3'b000;
      tick();
    end
    s2_in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    s0_clear = 0; s0_in_valid = 0; s0_a = 0; s0_b = 0; {s0_g, s0_l, s0_e} = 3'b000;
    s2_clear = 0; s2_in_valid = 0; s2_a = 0; s2_b = 0; {s2_g, s2_l, s2_e} = 3'b000;
    s4_clear = 0; s4_in_valid = 0; s4_a = 0; s4_b = 0; {s4_g, s4_l, s4_e} = 3'b000;

    //                clr v   a      b      gle     st     vec errc
    tbl[0]  = mk(0, 1, 8'h80, 8'h80, 3'b001, 2'b01, 1, 0);
    tbl[1]  = mk(0, 1, 8'hFF, 8'h80, 3'b100, 2'b01, 2, 0);
    tbl[2]  = mk(0, 1, 8'h80, 8'hFF, 3'b010, 2'b01, 3, 0);
    tbl[3]  = mk(0, 0, 8'h12, 8'h34, 3'b111, 2'b01, 3, 0);
    tbl[4]  = mk(0, 1, 8'h00, 8'h00, 3'b001, 2'b01, 4, 0);
    tbl[5]  = mk(0, 1, 8'h7F, 8'h80, 3'b010, 2'b01, 5, 0);
    tbl[6]  = mk(0, 1, 8'hFF, 8'h00, 3'b100, 2'b01, 6, 0);
    tbl[7]  = mk(1, 1, 8'h55, 8'h66, 3'b000, 2'b00, 0, 0);
    tbl[8]  = mk(0, 1, 8'hFF, 8'hFF, 3'b100, 2'b10, 1, 1);
    tbl[9]  = mk(0, 1, 8'h00, 8'h01, 3'b111, 2'b10, 2, 2);
    tbl[10] = mk(0, 1, 8'h00, 8'h01, 3'b010, 2'b10, 3, 2);
    tbl[11] = mk(0, 1, 8'hAA, 8'hAA, 3'b011, 2'b10, 4, 3);
    tbl[12] = mk(0, 0, 8'hAA, 8'hAA, 3'b000, 2'b10, 4, 3);
    tbl[13] = mk(1, 0, 8'h00, 8'h00, 3'b000, 2'b00, 0, 0);
    tbl[14] = mk(0, 1, 8'h10, 8'h20, 3'b010, 2'b01, 1, 0);
    tbl[15] = mk(0, 1, 8'h10, 8'h20, 3'b000, 2'b10, 2, 1);

    tick();
    tick();
    // Reset values while rst_n is still low.
    chk("rst_lat0_state", s0_state, 2'b00);
    chk("rst_lat0_err", s0_err, 1'b0);
    chk("rst_lat0_vec", s0_vec, 16'd0);
    chk("rst_lat0_errc", s0_errc, 16'd0);
    chk("rst_lat0_ff", {s0_ff_a, s0_ff_b, s0_ff_obs, s0_ff_exp}, 22'd0);
    chk("rst_lat2_state", s2_state, 2'b00);
    chk("rst_lat2_vec", s2_vec, 16'd0);
    chk("rst_cnt4_state", s4_state, 2'b00);
    chk("rst_cnt4_vec", s4_vec, 4'd0);
    rst_n = 1'b1;
    tick();

    // ---- LAT=0 directed table ----
    apply_rows(0, 10);
    chk_ff0("lat0_first_fail", 8'hFF, 8'hFF, 3'b100, 3'b001);
    apply_rows(11, 12);
    chk_ff0("lat0_ff_kept", 8'hFF, 8'hFF, 3'b100, 3'b001);
    apply_rows(13, 13);
    chk_ff0("lat0_ff_cleared", 8'h00, 8'h00, 3'b000, 3'b000);
    apply_rows(14, 15);
    chk_ff0("lat0_pass_to_fail", 8'h10, 8'h20, 3'b000, 3'b010);

    // ---- CNT_W=4 saturation ----
    for (int i = 0; i < 20; i++) begin
      s4_in_valid = 1'b1;
      s4_a = 8'(i);
      s4_b = 8'(i + 1);
      {s4_g, s4_l, s4_e} = 3'b100;
      tick();
      chk($sformatf("cnt4_vec_%0d", i), s4_vec, (i + 1 > 15) ? 15 : i + 1);
      chk($sformatf("cnt4_errc_%0d", i), s4_errc, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("cnt4_state", s4_state, 2'b10);
    chk("cnt4_ff", {s4_ff_a, s4_ff_b, s4_ff_obs, s4_ff_exp}, {8'h00, 8'h01, 3'b100, 3'b010});
    // clear together with a matching in_valid: the vector must be dropped.
    s4_clear = 1'b1;
    s4_in_valid = 1'b1;
    s4_a = 8'h03; s4_b = 8'h03;
    {s4_g, s4_l, s4_e} = 3'b001;
    tick();
    chk("cnt4_clr_state", s4_state, 2'b00);
    chk("cnt4_clr_err", s4_err, 1'b0);
    chk("cnt4_clr_vec", s4_vec, 4'd0);
    chk("cnt4_clr_errc", s4_errc, 4'd0);
    chk("cnt4_clr_ff", {s4_ff_a, s4_ff_b, s4_ff_obs, s4_ff_exp}, 22'd0);
    s4_clear = 1'b0;
    s4_in_valid = 1'b0;
    tick();
    chk("cnt4_after_clr_vec", s4_vec, 4'd0);

    // ---- LAT=2 aligned stream ----
    run_lat2(2);
    chk("lat2_ok_vec", s2_vec, 16'd16);
    chk("lat2_ok_errc", s2_errc, 16'd0);
    chk("lat2_ok_state", s2_state, 2'b01);
    chk("lat2_ok_err", s2_err, 1'b0);
    s2_clear = 1'b1;
    tick();
    s2_clear = 1'b0;
    chk("lat2_clr_vec", s2_vec, 16'd0);

    // ---- LAT=2 checker fed responses only 1 cycle late ----
    run_lat2(1);
    chk("lat2_skew_err", s2_err, 1'b1);
    chk("lat2_skew_state", s2_state, 2'b10);
    chk("lat2_skew_vec", s2_vec, 16'd16);
    chk("lat2_skew_errc", s2_errc, 16'd13);
    chk("lat2_skew_ff", {s2_ff_a, s2_ff_b, s2_ff_obs, s2_ff_exp},
        {8'h80, 8'h80, 3'b100, 3'b001});

    // ---- LAT=2 reset with a vector in flight ----
    s2_in_valid = 1'b1;
    s2_a = 8'h01; s2_b = 8'h02;
    {s2_g, s2_l, s2_e} = 3'b000;
    tick();
    s2_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("lat2_rst_state", s2_state, 2'b00);
    chk("lat2_rst_err", s2_err, 1'b0);
    chk("lat2_rst_vec", s2_vec, 16'd0);
    chk("lat2_rst_errc", s2_errc, 16'd0);
    chk("lat2_rst_ff", {s2_ff_a, s2_ff_b, s2_ff_obs, s2_ff_exp}, 22'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("lat2_postrst_vec", s2_vec, 16'd0);
    chk("lat2_postrst_errc", s2_errc, 16'd0);
    chk("lat2_postrst_state", s2_state, 2'b00);
    // Checking restarts cleanly: one correct vector after the release.
    s2_in_valid = 1'b1;
    s2_a = 8'h05; s2_b = 8'h05;
    tick();
    s2_in_valid = 1'b0;
    tick();
    {s2_g, s2_l, s2_e} = 3'b001;
    tick();
    {s2_g, s2_l, s2_e} = 3'b000;
    chk("lat2_restart_vec", s2_vec, 16'd1);
    chk("lat2_restart_state", s2_state, 2'b01);
    chk("lat2_restart_errc", s2_errc, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
